// File: rtl/adc_serial_rx_multi_if.sv
// Output handshake bundle of adc_serial_rx_multi: formatted words and raw frames under valid/ready.
interface adc_serial_rx_multi_if #(
    parameter int unsigned NCH        = 2,
    parameter int unsigned OUT_W      = 29,
    parameter int unsigned FRAME_BITS = 16
);
    logic                       out_valid;
    logic                       out_ready;
    logic [NCH*OUT_W-1:0]       data_out;
    logic [NCH*FRAME_BITS-1:0]  raw_data;

    modport master (output out_valid, output data_out, output raw_data, input out_ready);
    modport slave  (input out_valid, input data_out, input raw_data, output out_ready);
endinterface

// File: rtl/adc_serial_rx_multi.sv
// Multi-channel SPI-style ADC receiver: synchronises CS_n/SCLK/SDATA, shifts one frame per
// CS_n low period, publishes sign-extended fixed-point words with short-frame/overrun pulses.
module adc_serial_rx_multi #(
    parameter int unsigned NCH         = 2,
    parameter int unsigned FRAME_BITS  = 16,
    parameter int unsigned DATA_BITS   = 12,
    parameter int unsigned OUT_W       = 29,
    parameter int unsigned FRAC_SHIFT  = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cs_n,
    input  logic                        sclk,
    input  logic [NCH-1:0]              sdata,
    input  logic                        offset_bin,
    output logic                        frame_err,
    output logic                        overrun,
    adc_serial_rx_multi_if.master       out_if
);
    localparam int unsigned CNT_W  = $clog2(FRAME_BITS + 1);
    localparam int unsigned SIGN_W = OUT_W - FRAC_SHIFT;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SHIFT   = 2'd1;
    localparam logic [1:0] ST_WAIT_CS = 2'd2;

    logic [SYNC_STAGES-1:0]          cs_sync_q;
    logic [SYNC_STAGES-1:0]          sclk_sync_q;
    logic [SYNC_STAGES-1:0][NCH-1:0] sdata_sync_q;
    logic                            cs_prev_q;
    logic                            sclk_prev_q;

    logic [1:0]                      state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [NCH-1:0][FRAME_BITS-1:0]  shift_q, shift_d;
    logic                            valid_q, valid_d;
    logic [NCH*OUT_W-1:0]            data_q, data_d;
    logic [NCH*FRAME_BITS-1:0]       raw_q, raw_d;
    logic                            frame_err_q, frame_err_d;
    logic                            overrun_q, overrun_d;
    logic                            publish;

    logic                            cs_s, sclk_s;
    logic [NCH-1:0]                  sdata_s;
    logic                            cs_fall, cs_rise, sclk_fall;

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sdata_s   = sdata_sync_q[SYNC_STAGES-1];
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;

    // Take the LSB field, optionally flip its MSB, sign-extend and scale by 2^FRAC_SHIFT.
    function automatic logic [OUT_W-1:0] fmt_word(input logic [FRAME_BITS-1:0] sh, input logic ob);
        logic [DATA_BITS-1:0]     f;
        logic signed [SIGN_W-1:0] ext;
        f              = sh[DATA_BITS-1:0];
        f[DATA_BITS-1] = f[DATA_BITS-1] ^ ob;
        ext            = SIGN_W'($signed(f));
        return OUT_W'(ext) << FRAC_SHIFT;
    endfunction

    // Synchronisers reset low so reset release never fakes a CS_n or SCLK falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync_q    <= '0;
            sclk_sync_q  <= '0;
            sdata_sync_q <= '0;
            cs_prev_q    <= 1'b0;
            sclk_prev_q  <= 1'b0;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            raw_q        <= '0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata};
            cs_prev_q    <= cs_s;
            sclk_prev_q  <= sclk_s;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            raw_q        <= raw_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        valid_d     = valid_q & ~out_if.out_ready;
        data_d      = data_q;
        raw_d       = raw_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        publish     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            ST_SHIFT: begin
                if (sclk_fall) begin
                    for (int k = 0; k < int'(NCH); k++) begin
                        shift_d[k] = {shift_q[k][FRAME_BITS-2:0], sdata_s[k]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Edge in the CS_n rise cycle counts before the completeness check.
                if (cnt_d == CNT_W'(FRAME_BITS)) begin
                    if (cs_rise) begin
                        publish = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_CS;
                    end
                end else if (cs_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_WAIT_CS: begin
                if (cs_rise) begin
                    publish = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (publish) begin
            overrun_d = valid_q & ~out_if.out_ready;
            valid_d   = 1'b1;
            for (int k = 0; k < int'(NCH); k++) begin
                data_d[k*OUT_W +: OUT_W]          = fmt_word(shift_d[k], offset_bin);
                raw_d[k*FRAME_BITS +: FRAME_BITS] = shift_d[k];
            end
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.data_out  = data_q;
    assign out_if.raw_data  = raw_q;
    assign frame_err        = frame_err_q;
    assign overrun          = overrun_q;
endmodule

// File: tb/tb_adc_serial_rx_multi.sv
// Directed bench for adc_serial_rx_multi: frame-level model checked every cycle plus literal pins.
module tb_adc_serial_rx_multi;
    localparam int unsigned NCH   = 2;
    localparam int unsigned FB    = 16;
    localparam int unsigned OUT_W = 29;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           cs_n = 1'b1;
    logic           sclk = 1'b1;
    logic [NCH-1:0] sdata = '0;
    logic           offset_bin = 1'b1;
    logic           frame_err, overrun;

    adc_serial_rx_multi_if #(.NCH(NCH), .OUT_W(OUT_W), .FRAME_BITS(FB)) bus ();

    adc_serial_rx_multi #(
        .NCH(NCH), .FRAME_BITS(FB), .DATA_BITS(12), .OUT_W(OUT_W), .FRAC_SHIFT(6), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .sclk(sclk), .sdata(sdata),
        .offset_bin(offset_bin), .frame_err(frame_err), .overrun(overrun), .out_if(bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;
    logic        exp_valid = 1'b0;
    logic [28:0] exp_data [2] = '{29'd0, 29'd0};
    logic [15:0] exp_raw  [2] = '{16'd0, 16'd0};
    int          exp_ferr = 0, exp_ovr = 0, ferr_seen = 0, ovr_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Value of the 12-bit code times 64, wrapped to 29 bits.
    function automatic logic [28:0] fmt(input logic [15:0] fr, input logic ob);
        int code, v;
        code = int'(fr[11:0]);
        if (ob) v = code - 2048;
        else    v = (code >= 2048) ? code - 4096 : code;
        v = v * 64;
        return 29'(v);
    endfunction

    // Per-cycle compare against the frame-level model; pulses are counted, so a stretched pulse shows up.
    always @(negedge clk) begin
        if (frame_err === 1'b1) ferr_seen++;
        if (overrun === 1'b1)   ovr_seen++;
        if (chk_en && !reset) begin
            check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
            check("data_ch0", 64'(bus.data_out[28:0]), 64'(exp_data[0]));
            check("data_ch1", 64'(bus.data_out[57:29]), 64'(exp_data[1]));
            check("raw_ch0", 64'(bus.raw_data[15:0]), 64'(exp_raw[0]));
            check("raw_ch1", 64'(bus.raw_data[31:16]), 64'(exp_raw[1]));
            check("frame_err_count", 64'(ferr_seen), 64'(exp_ferr));
            check("overrun_count", 64'(ovr_seen), 64'(exp_ovr));
        end
    end

    task automatic clock_bits(input logic [15:0] f0, input logic [15:0] f1, input int nedges);
        for (int i = 0; i < nedges; i++) begin
            sdata[0] = (i < 16) ? f0[15-i] : 1'b1;
            sdata[1] = (i < 16) ? f1[15-i] : 1'b1;
            #40 sclk = 1'b0;
            #40 sclk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [15:0] f0, input logic [15:0] f1, input int nedges);
        @(negedge clk);
        cs_n = 1'b0;
        #80;
        clock_bits(f0, f1, nedges);
        #40;
        chk_en = 1'b0;
        cs_n   = 1'b1;
        #150;
        if (nedges >= 16) begin
            if (exp_valid) exp_ovr++;
            exp_valid   = 1'b1;
            exp_raw[0]  = f0;
            exp_raw[1]  = f1;
            exp_data[0] = fmt(f0, offset_bin);
            exp_data[1] = fmt(f1, offset_bin);
        end else begin
            exp_ferr++;
        end
        chk_en = 1'b1;
    endtask

    task automatic consume();
        @(negedge clk);
        check("valid_before_ready", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        chk_en        = 1'b0;
        @(negedge clk);
        check("valid_cleared_next_cycle", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;
        exp_valid     = 1'b0;
        chk_en        = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_valid", 64'(bus.out_valid), 64'd0);
        check("reset_data", 64'(bus.data_out), 64'd0);
        check("reset_raw", 64'(bus.raw_data), 64'd0);
        check("reset_pulses", 64'({frame_err, overrun}), 64'd0);
        reset = 1'b0;
        #100;
        chk_en = 1'b1;

        // 1: offset-binary full scale and mid-scale
        send_frame(16'h0FFF, 16'h0800, 16);
        check("t1_valid", 64'(bus.out_valid), 64'd1);
        check("t1_ch0", 64'(bus.data_out[28:0]), 64'h0001FFC0);
        check("t1_ch1", 64'(bus.data_out[57:29]), 64'd0);
        check("t1_raw", 64'(bus.raw_data), 64'h08000FFF);
        check("t1_no_pulses", 64'(ferr_seen + ovr_seen), 64'd0);
        consume();

        // 2: negative full scale in both code formats
        send_frame(16'h0000, 16'h0123, 16);
        check("t2_ob_zero", 64'(bus.data_out[28:0]), 64'h1FFE0000);
        consume();
        offset_bin = 1'b0;
        send_frame(16'h0800, 16'h0FFF, 16);
        check("t2_tc_min", 64'(bus.data_out[28:0]), 64'h1FFE0000);
        check("t2_tc_minus1", 64'(bus.data_out[57:29]), 64'h1FFFFFC0);
        consume();
        send_frame(16'h07FF, 16'h0001, 16);
        check("t2_tc_max", 64'(bus.data_out[28:0]), 64'h0001FFC0);
        consume();
        offset_bin = 1'b1;

        // 3: short frame, then recovery
        send_frame(16'h0FFF, 16'h0FFF, 9);
        check("t3_ferr_once", 64'(ferr_seen), 64'd1);
        check("t3_no_valid", 64'(bus.out_valid), 64'd0);
        send_frame(16'h0321, 16'h0CDE, 16);
        check("t3_recovered_raw", 64'(bus.raw_data), 64'h0CDE0321);
        consume();

        // 4: overrun on an unconsumed word
        send_frame(16'h0123, 16'h0456, 16);
        send_frame(16'h0F0F, 16'h0001, 16);
        check("t4_overrun_once", 64'(ovr_seen), 64'd1);
        check("t4_second_ch0", 64'(bus.data_out[28:0]), 64'h0001C3C0);
        consume();

        // 5: extra SCLK edges after a complete frame are ignored
        send_frame(16'h0ABC, 16'h0555, 20);
        check("t5_raw_ch0", 64'(bus.raw_data[15:0]), 64'h0ABC);
        check("t5_raw_ch1", 64'(bus.raw_data[31:16]), 64'h0555);

        // 6: reset mid-frame with a word still pending, released while CS_n stays low
        @(negedge clk);
        cs_n = 1'b0;
        #80;
        clock_bits(16'hFFFF, 16'hFFFF, 8);
        chk_en = 1'b0;
        reset  = 1'b1;
        #30;
        check("t6_reset_valid", 64'(bus.out_valid), 64'd0);
        reset       = 1'b0;
        exp_valid   = 1'b0;
        exp_data[0] = '0;
        exp_data[1] = '0;
        exp_raw[0]  = '0;
        exp_raw[1]  = '0;
        #100;
        chk_en = 1'b1;
        clock_bits(16'hFFFF, 16'hFFFF, 8);
        #40;
        cs_n = 1'b1;
        #150;
        check("t6_no_valid", 64'(bus.out_valid), 64'd0);
        check("t6_no_ferr", 64'(ferr_seen), 64'd1);
        send_frame(16'h0246, 16'h0987, 16);
        check("t6_frame_raw", 64'(bus.raw_data), 64'h09870246);
        consume();

        #50;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/adc_serial_rx_multi.md
Name: adc_serial_rx_multi

Overview:
Parametrised multi-channel receiver for SPI-style serial ADCs with one CS_n/SCLK pair and NCH parallel SDATA lines, e.g. a dual-channel 12-bit converter. It runs entirely in the system clock domain: it synchronises the ADC pins, detects SCLK falling edges and shifts in one frame per CS_n low period. It then formats each channel as a sign-extended fixed-point word and hands it to the DSP path over a valid/ready handshake. It also flags short frames and unconsumed-sample overruns.

Parameters:
NCH, 2, number of SDATA lines captured in parallel
FRAME_BITS, 16, SCLK falling edges per frame
DATA_BITS, 12, significant bits, taken as the LSBs of the frame
OUT_W, 29, formatted output width per channel
FRAC_SHIFT, 6, zero LSBs appended; constraint OUT_W >= DATA_BITS+FRAC_SHIFT
SYNC_STAGES, 2, synchroniser depth on cs_n, sclk and sdata (minimum 2)

Ports:
clk  in  1  system clock; must be at least 4x the SCLK frequency
reset  in  1  asynchronous, active-high
cs_n  in  1  ADC chip select, active-low, asynchronous to clk
sclk  in  1  ADC serial clock, asynchronous to clk
sdata  in  NCH  serial data, one bit per channel
offset_bin  in  1  1 = ADC code is offset binary, so the MSB is inverted; 0 = code is already two's complement
out_ready  in  1  consumer accepts the current output word
out_valid  out  1  data_out and raw_data hold an unconsumed frame
data_out  out  NCH*OUT_W  formatted words; channel k occupies [k*OUT_W +: OUT_W]
raw_data  out  NCH*FRAME_BITS  unformatted shift registers captured at frame end
frame_err  out  1  one-cycle pulse: CS_n rose before FRAME_BITS edges were received
overrun  out  1  one-cycle pulse: a new frame overwrote an unconsumed word

Behaviour:
- Reset values: all outputs are 0. FSM is IDLE, bit counter and shift registers are 0.
  - cs_n synchroniser resets to 0 and sclk synchroniser resets to 0. This prevents a spurious CS or SCLK falling edge after reset release.
- Synchronised cs_n, sclk and sdata are used everywhere. sclk_fall = previous synced sclk was 1 and current is 0. cs_fall and cs_rise are defined the same way on synced cs_n.
- Pin-to-action latency is SYNC_STAGES+1 clk cycles. sdata is sampled at the same synchroniser depth as sclk.
- FSM states:
  - IDLE: on cs_fall go to SHIFT; bit counter = 0; shift registers = 0. If cs_n is already low at reset release, no frame starts until cs_n goes high and then low again.
  - SHIFT: on each sclk_fall, every channel shifts left with sdata[k] entering at the LSB, and the counter increments. When the counter reaches FRAME_BITS, go to WAIT_CS.
    - cs_rise while counter < FRAME_BITS: pulse frame_err, discard the data, go to IDLE. The outputs are unchanged.
    - sclk_fall and cs_rise in the same cycle: the edge is shifted first, then the completion check applies.
  - WAIT_CS: further sclk_fall edges are ignored and the shift registers are frozen. On cs_rise, publish the frame and go to IDLE.
- Publish happens in the cs_rise cycle; out_valid, data_out and raw_data update on the next clk edge.
  - If out_valid=1 and out_ready=0 at publish, the new frame overwrites the old one, overrun pulses for one cycle and out_valid stays 1.
  - If out_ready=1 in the same cycle as publish, the old word is consumed, there is no overrun, and the new word is loaded with out_valid=1.
- Handshake: a transfer occurs when out_valid && out_ready, which clears out_valid next cycle. data_out and raw_data hold their values until the next publish. out_ready while out_valid=0 has no effect.
- Formatting, per channel:
  - f = shift[DATA_BITS-1:0]; if offset_bin, invert f[DATA_BITS-1].
  - Sign-extend f to OUT_W-FRAC_SHIFT bits, then append FRAC_SHIFT zeros.
  - offset_bin is sampled at publish time.
- Bits above DATA_BITS in the frame (leading zeros) go only to raw_data.
- Reset mid-frame aborts immediately; no frame_err and no publish occur.

Test Plan:
1. Defaults, offset_bin=1: ch0 frame 16'h0FFF, ch1 frame 16'h0800, CS_n then high. Expect out_valid=1, ch0 data_out=29'h0001FFC0, ch1 data_out=0, raw_data={16'h0800,16'h0FFF}, frame_err=0 and overrun=0.
2. offset_bin=1, ch0 frame 16'h0000 gives 29'h1FFE0000 (-2048·64). With offset_bin=0, ch0 frame 16'h0800 gives 29'h1FFE0000 and 16'h07FF gives 29'h0001FFC0.
3. Short frame: 9 SCLK edges, then CS_n high. Expect frame_err high for exactly 1 cycle, out_valid still 0, and the next full frame captured correctly.
4. Overrun: two full frames with out_ready=0. Expect overrun pulsed once at the second publish, data_out equal to the second frame, and out_valid clearing one cycle after out_ready=1.
5. 20 SCLK edges inside one CS_n low period with frame 16'h0ABC followed by 4 extra 1-bits: raw_data ch0=16'h0ABC, so the extra edges are ignored.
6. Assert reset after 8 edges, release it with CS_n still low: no output and no frame_err. A subsequent CS_n high-then-low frame is received correctly.
